// File: rtl/sign_extender_pkg.sv
// sign_extender_pkg: immediate-format encodings and datapath widths shared by the extender and its users.
// Revision 1.0
`default_nettype none

`ifndef SIGN_EXTENDER_PKG_MACROS
`define SIGN_EXTENDER_PKG_MACROS
`define Itype  2'b00
`define Dtype  2'b01
`define CBtype 2'b10
`define Btype  2'b11
`endif

package sign_extender_pkg;

  localparam int INSTR_W = 26;
  localparam int DATA_W  = 64;

  localparam logic [1:0] Itype  = 2'b00;
  localparam logic [1:0] Dtype  = 2'b01;
  localparam logic [1:0] CBtype = 2'b10;
  localparam logic [1:0] Btype  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/sign_extender.sv
// sign_extender: selects the immediate field by format, extends it to 64 bits, and offers a registered copy.
// Revision 1.0
`default_nettype none

module sign_extender
  import sign_extender_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   Instruction,
  input  logic [1:0]           SignOp,
  output logic [DATA_W-1:0]    SignExOut,
  output logic [DATA_W-1:0]    SignExOutQ
);

  logic [DATA_W-1:0] sign_ex_d;
  logic [DATA_W-1:0] sign_ex_q;

  // Branch formats carry word offsets, hence the two appended zero bits.
  always_comb begin
    sign_ex_d = '0;
    case (SignOp)
      Itype:   sign_ex_d = {52'b0, Instruction[21:10]};
      Dtype:   sign_ex_d = {{55{Instruction[20]}}, Instruction[20:12]};
      CBtype:  sign_ex_d = {{43{Instruction[23]}}, Instruction[23:5], 2'b00};
      Btype:   sign_ex_d = {{36{Instruction[25]}}, Instruction[25:0], 2'b00};
      default: sign_ex_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_ex_q <= '0;
    end else begin
      sign_ex_q <= sign_ex_d;
    end
  end

  assign SignExOut  = sign_ex_d;
  assign SignExOutQ = sign_ex_q;

endmodule

`default_nettype wire

// File: tb/tb_sign_extender.sv
// tb_sign_extender: directed and random checks of the combinational and registered immediate outputs.
`default_nettype none

module tb_sign_extender;

  logic        clk;
  logic        rst_n;
  logic [25:0] Instruction;
  logic [1:0]  SignOp;
  logic [63:0] SignExOut;
  logic [63:0] SignExOutQ;

  int checks;
  int failures;

  sign_extender dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Instruction (Instruction),
    .SignOp      (SignOp),
    .SignExOut   (SignExOut),
    .SignExOutQ  (SignExOutQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] op, input logic [25:0] i);
    logic [63:0] r;
    case (op)
      2'b00:   r = {52'b0, i[21:10]};
      2'b01:   r = {{55{i[20]}}, i[20:12]};
      2'b10:   r = {{43{i[23]}}, i[23:5], 2'b00};
      default: r = {{36{i[25]}}, i[25:0], 2'b00};
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [1:0] op, input logic [25:0] ins);
    SignOp      = op;
    Instruction = ins;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n       = 1'b0;
    SignOp      = 2'b00;
    Instruction = 26'h0;

    // Reset clears the register with no clock edge yet.
    #2;
    chk("reset_q_no_clock", SignExOutQ, 64'h0);

    // Directed combinational vectors, applied away from clock edges.
    apply(2'b00, 26'h0003C00); chk("itype_0f",        SignExOut, 64'h000000000000000F);
    apply(2'b00, 26'h3FFFFFF); chk("itype_all_ones",  SignExOut, 64'h0000000000000FFF);
    apply(2'b01, 26'h0100000); chk("dtype_neg",       SignExOut, 64'hFFFFFFFFFFFFFF00);
    apply(2'b01, 26'h00FF000); chk("dtype_pos",       SignExOut, 64'h00000000000000FF);
    apply(2'b10, 26'h0800000); chk("cbtype_neg",      SignExOut, 64'hFFFFFFFFFFF00000);
    apply(2'b10, 26'h0000020); chk("cbtype_one",      SignExOut, 64'h0000000000000004);
    apply(2'b11, 26'h2000000); chk("btype_neg",       SignExOut, 64'hFFFFFFFFF8000000);
    apply(2'b11, 26'h1FFFFFF); chk("btype_pos_max",   SignExOut, 64'h0000000007FFFFFC);
    apply(2'b01, 26'h3E00FFF); chk("dtype_ignore_oth", SignExOut, 64'h0000000000000000);
    apply(2'b00, 26'h3C003FF); chk("itype_ignore_oth", SignExOut, 64'h0000000000000000);

    // Register holds zero across clock edges while reset is asserted.
    @(posedge clk); #1;
    chk("reset_q_held", SignExOutQ, 64'h0);

    // Release reset and capture a Btype immediate.
    @(negedge clk);
    rst_n = 1'b1;
    SignOp      = 2'b11;
    Instruction = 26'h2000000;
    #1;
    chk("q_before_edge", SignExOutQ, 64'h0);
    @(posedge clk); #1;
    chk("q_btype_capture", SignExOutQ, 64'hFFFFFFFFF8000000);

    // New input changes SignExOut at once but SignExOutQ only on the next edge.
    @(negedge clk);
    SignOp      = 2'b00;
    Instruction = 26'h0003C00;
    #1;
    chk("comb_itype_now", SignExOut,  64'h000000000000000F);
    chk("q_one_cycle_lat", SignExOutQ, 64'hFFFFFFFFF8000000);
    @(posedge clk); #1;
    chk("q_itype_capture", SignExOutQ, 64'h000000000000000F);

    // Mid-cycle reset clears the register immediately, comb path untouched.
    #2;
    rst_n = 1'b0;
    #1;
    chk("q_async_clear", SignExOutQ, 64'h0);
    chk("comb_during_rst", SignExOut, 64'h000000000000000F);

    @(negedge clk);
    rst_n = 1'b1;
    SignOp      = 2'b10;
    Instruction = 26'h0000020;
    @(posedge clk); #1;
    chk("q_after_rerelease", SignExOutQ, 64'h0000000000000004);

    // Random regression, 100 vectors per format.
    for (int op = 0; op < 4; op++) begin
      for (int n = 0; n < 100; n++) begin
        logic [25:0] r;
        r = 26'($urandom);
        @(negedge clk);
        SignOp      = 2'(op);
        Instruction = r;
        #1;
        chk($sformatf("rand_op%0d_%h", op, r), SignExOut, model(2'(op), r));
        @(posedge clk); #1;
        chk($sformatf("rand_q_op%0d_%h", op, r), SignExOutQ, model(2'(op), r));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
